// File: rtl/vga_pixel_timing_gen_if.sv
// Avalon-ST pixel stream between a video source and the VGA timing generator.
// The source drives data/valid/sop, the sink drives ready.
interface vga_pixel_timing_gen_if #(
   parameter int CB = 8
);
   logic [3*CB-1:0] in_data;
   logic            in_valid;
   logic            in_sop;
   logic            in_ready;

   modport master (output in_data, output in_valid, output in_sop, input in_ready);
   modport slave  (input in_data, input in_valid, input in_sop, output in_ready);
endinterface

// File: rtl/vga_pixel_timing_gen.sv
// VGA timing generator in the pixel-clock domain: waits for PLL lock, locks each
// frame to startofpacket, drives registered DAC pins and sticky error flags.
module vga_pixel_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CB       = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pll_locked,
   vga_pixel_timing_gen_if.slave   st,
   output logic [CB-1:0]           vga_r,
   output logic [CB-1:0]           vga_g,
   output logic [CB-1:0]           vga_b,
   output logic                    vga_hs,
   output logic                    vga_vs,
   output logic                    vga_blank_n,
   output logic                    vga_sync_n,
   output logic                    underflow,
   output logic                    sop_err,
   input  logic                    err_clr
);
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {WAIT_LOCK, SEEK, RUN} state_e;

   state_e          state_q, state_d;
   logic            lk_m_q, lk_m_d, lk_s_q, lk_s_d;
   logic [HW-1:0]   h_q, h_d;
   logic [VW-1:0]   v_q, v_d;
   logic [3*CB-1:0] rgb_q, rgb_d;
   logic            hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic            underflow_q, underflow_d, sop_err_q, sop_err_d;

   logic act, origin, hs_i, vs_i, idle;
   logic rdy, disp, take, sop_bad, uf_set;

   assign act    = (h_q < H_ACT) && (v_q < V_ACT);
   assign origin = (h_q == '0) && (v_q == '0);
   assign hs_i   = !((h_q >= HS_BEG) && (h_q < HS_END));
   assign vs_i   = !((v_q >= VS_BEG) && (v_q < VS_END));
   // Losing lock blanks the pins at once instead of waiting for the state change.
   assign idle   = !lk_s_q || (state_q == WAIT_LOCK);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= WAIT_LOCK;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LOCK: if (lk_s_q)  state_d = SEEK;
         SEEK:      if (take)    state_d = RUN;
         RUN:       if (sop_bad) state_d = SEEK;
         default:                state_d = WAIT_LOCK;
      endcase
      if (!lk_s_q) state_d = WAIT_LOCK;
   end

   // Output logic; the sop beat that starts RUN is displayed as pixel (0,0)
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      rdy  = 1'b0;
      disp = 1'b0;
      take = (state_q == SEEK) && origin && st.in_valid && st.in_sop;
      case (state_q)
         SEEK: begin
            rdy  = st.in_valid && (!st.in_sop || origin);
            disp = take;
         end
         RUN: begin
            rdy  = act;
            disp = 1'b1;
         end
         default: ;
      endcase
      if (!lk_s_q) begin
         rdy  = 1'b0;
         disp = 1'b0;
         take = 1'b0;
      end
      sop_bad = (state_q == RUN) && rdy && st.in_valid && (st.in_sop != origin);
      uf_set  = (state_q == RUN) && lk_s_q && act && !st.in_valid;
   end

   assign st.in_ready = rdy;

   // Datapath: synchroniser, counters, pin stage, sticky flags
   always_comb begin
      lk_m_d = pll_locked;
      lk_s_d = lk_m_q;

      h_d = '0;
      v_d = '0;
      if (!idle) begin
         h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
         v_d = v_q;
         if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end

      hs_d    = idle || hs_i;
      vs_d    = idle || vs_i;
      blank_d = disp && act;
      rgb_d   = (disp && act && st.in_valid) ? st.in_data : '0;

      underflow_d = err_clr ? 1'b0 : (underflow_q || uf_set);
      sop_err_d   = err_clr ? 1'b0 : (sop_err_q || sop_bad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: both synchroniser stages reset to 0 so a reset always restarts from WAIT_LOCK.
         lk_m_q      <= 1'b0;
         lk_s_q      <= 1'b0;
         h_q         <= '0;
         v_q         <= '0;
         rgb_q       <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         blank_q     <= 1'b0;
         underflow_q <= 1'b0;
         sop_err_q   <= 1'b0;
      end else begin
         lk_m_q      <= lk_m_d;
         lk_s_q      <= lk_s_d;
         h_q         <= h_d;
         v_q         <= v_d;
         rgb_q       <= rgb_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         blank_q     <= blank_d;
         underflow_q <= underflow_d;
         sop_err_q   <= sop_err_d;
      end
   end

   assign vga_r       = rgb_q[3*CB-1:2*CB];
   assign vga_g       = rgb_q[2*CB-1:CB];
   assign vga_b       = rgb_q[CB-1:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_q;
   assign vga_sync_n  = 1'b0;
   assign underflow   = underflow_q;
   assign sop_err     = sop_err_q;
endmodule

// File: tb/tb_vga_pixel_timing_gen.sv
// Directed bench for vga_pixel_timing_gen on a shrunken 24x8 raster (16x4 visible)
// so several whole frames fit in a short run.
module tb_vga_pixel_timing_gen;
   localparam int HA = 16, HF = 2, HS = 4, HB = 2;
   localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic clk = 1'b0;
   logic rst, pll_locked, err_clr;
   logic [7:0] vga_r, vga_g, vga_b;
   logic vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow, sop_err;

   vga_pixel_timing_gen_if #(.CB(8)) src ();

   vga_pixel_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CB(8)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .st(src),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .underflow(underflow), .sop_err(sop_err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int ph, pv;
   bit mode_run;
   int err_pins, err_rdy, n_rdy, n_blank, n_hs, n_vs;

   function automatic logic [23:0] pat(input int h, input int v);
      return {8'(h ^ v), 8'(h), 8'(v)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pixel clock: present the beat for the current raster position, check
   // ready before the edge and the registered pins after it.
   task automatic cyc(input bit v_in, input bit s_in, input bit clr);
      bit org, act_e, vis, rdy_e, hs_e, vs_e, bl_e;
      logic [23:0] px, rgb_e;
      org   = (ph == 0) && (pv == 0);
      act_e = (ph < HA) && (pv < VA);
      px    = pat(ph, pv);
      src.in_valid = v_in;
      src.in_sop   = s_in;
      src.in_data  = px;
      err_clr      = clr;
      #1;
      rdy_e = mode_run ? act_e : (v_in && (!s_in || org));
      if (src.in_ready !== rdy_e) err_rdy++;
      if (src.in_ready === 1'b1) n_rdy++;
      vis = mode_run || (v_in && s_in && org);
      if (mode_run) begin
         if (v_in && act_e && (s_in != org)) mode_run = 1'b0;
      end else if (v_in && s_in && org) begin
         mode_run = 1'b1;
      end
      tick();
      hs_e  = !((ph >= HA + HF) && (ph < HA + HF + HS));
      vs_e  = !((pv >= VA + VF) && (pv < VA + VF + VS));
      bl_e  = vis && act_e;
      rgb_e = (bl_e && v_in) ? px : 24'h0;
      if (vga_hs !== hs_e || vga_vs !== vs_e || vga_blank_n !== bl_e ||
          {vga_r, vga_g, vga_b} !== rgb_e) err_pins++;
      if (vga_hs === 1'b0) n_hs++;
      if (vga_vs === 1'b0) n_vs++;
      if (vga_blank_n === 1'b1) n_blank++;
      err_clr = 1'b0;
      if (ph == HT - 1) begin
         ph = 0;
         pv = (pv == VT - 1) ? 0 : pv + 1;
      end else begin
         ph = ph + 1;
      end
   endtask

   task automatic check_phase(input string tag, input int rdy_e, input int bl_e,
                              input int hs_e, input int vs_e);
      check({tag, "_pins"},    err_pins, 0);
      check({tag, "_rdy_seq"}, err_rdy,  0);
      check({tag, "_rdy_cnt"}, n_rdy,    rdy_e);
      check({tag, "_blank"},   n_blank,  bl_e);
      check({tag, "_hs_low"},  n_hs,     hs_e);
      check({tag, "_vs_low"},  n_vs,     vs_e);
      err_pins = 0; err_rdy = 0; n_rdy = 0; n_blank = 0; n_hs = 0; n_vs = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      err_pins = 0; err_rdy = 0; n_rdy = 0; n_blank = 0; n_hs = 0; n_vs = 0;
      mode_run = 1'b0; ph = 0; pv = 0;
      rst = 1'b1; pll_locked = 1'b0; err_clr = 1'b0;
      src.in_valid = 1'b1; src.in_sop = 1'b0; src.in_data = 24'h0;
      repeat (2) tick();
      check("rst_hs",        vga_hs,      1);
      check("rst_vs",        vga_vs,      1);
      check("rst_blank",     vga_blank_n, 0);
      check("rst_rgb",       {vga_r, vga_g, vga_b}, 0);
      check("rst_sync_n",    vga_sync_n,  0);
      check("rst_ready",     src.in_ready, 0);
      check("rst_underflow", underflow,   0);
      check("rst_sop_err",   sop_err,     0);

      rst = 1'b0;
      repeat (3) tick();
      check("nolock_ready", src.in_ready, 0);
      check("nolock_hs",    vga_hs,       1);

      // Lock arrives: two synchroniser stages, then SEEK on the third edge
      pll_locked = 1'b1;
      tick();
      tick();
      check("lock_e2_ready", src.in_ready, 0);
      tick();
      check("lock_e3_ready", src.in_ready, 1);
      check("lock_e3_hs",    vga_hs,       1);

      // SEEK frame: non-sop beats are all accepted and dropped, raster runs
      for (int i = 0; i < HT * VT; i++) cyc(1'b1, 1'b0, 1'b0);
      check_phase("seek", HT * VT, 0, HS * VT, VS * HT);

      // Frame 1: aligned sop, full pattern displayed
      for (int i = 0; i < HT * VT; i++) cyc(1'b1, (ph == 0) && (pv == 0), 1'b0);
      check_phase("frame1", HA * VA, HA * VA, HS * VT, VS * HT);
      check("frame1_underflow", underflow, 0);
      check("frame1_sop_err",   sop_err,   0);

      // Frame 2: source stalls for 10 visible pixels on line 1
      for (int i = 0; i < HT * VT; i++)
         cyc(!((pv == 1) && (ph >= 3) && (ph <= 12)), (ph == 0) && (pv == 0), 1'b0);
      check_phase("frame2", HA * VA, HA * VA, HS * VT, VS * HT);
      check("frame2_underflow", underflow, 1);
      check("frame2_sop_err",   sop_err,   0);

      // Frame 3: flag clearing, clear-over-set priority, then a misplaced sop
      cyc(1'b1, 1'b1, 1'b1);
      check("clr_underflow", underflow, 0);
      cyc(1'b0, 1'b0, 1'b1);
      check("clr_priority", underflow, 0);
      cyc(1'b0, 1'b0, 1'b0);
      check("uf_set_again", underflow, 1);
      cyc(1'b1, 1'b0, 1'b1);
      check("clr_again", underflow, 0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check("sop_mid_err", sop_err, 1);
      cyc(1'b1, 1'b0, 1'b0);
      check("sop_mid_seek_blank", vga_blank_n, 0);
      while (!((ph == 0) && (pv == 0))) cyc(1'b1, 1'b0, 1'b0);
      check_phase("frame3", HT * VT, 6, HS * VT, VS * HT);

      // Frame 4: resync on the next sop; sop_err cleared part way through
      for (int i = 0; i < HT * VT; i++) begin
         cyc(1'b1, (ph == 0) && (pv == 0), (ph == 1) && (pv == 0));
         if ((ph == 2) && (pv == 0)) check("sop_err_clr", sop_err, 0);
      end
      check_phase("frame4", HA * VA, HA * VA, HS * VT, VS * HT);

      // Frame 5: missing sop at (0,0), then lock drops during vsync/hsync
      cyc(1'b1, 1'b0, 1'b0);
      check("sop_missing_err", sop_err, 1);
      while (!((ph == 16) && (pv == 5))) cyc(1'b1, 1'b0, 1'b0);
      check_phase("frame5", 5 * HT + 16, 1, 5 * HS, 16);

      pll_locked   = 1'b0;
      src.in_valid = 1'b1;
      src.in_sop   = 1'b0;
      repeat (3) tick();
      check("unlock_hs",    vga_hs,       1);
      check("unlock_vs",    vga_vs,       1);
      check("unlock_blank", vga_blank_n,  0);
      check("unlock_rgb",   {vga_r, vga_g, vga_b}, 0);
      check("unlock_ready", src.in_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
